// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and the LSU state encoding.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } lsu_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-enable generation, store lane replication and load lane extraction.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] byte_lane;
  logic [31:0] half_lane;

  // funct3[2] selects zero extension; funct3[1:0] is the access size.
  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    byte_lane = rdata >> {addr_lo, 3'b000};
    half_lane = rdata >> {addr_lo[1], 4'b0000};
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = funct3[2] ? {24'b0, byte_lane[7:0]}
                              : {{24{byte_lane[7]}}, byte_lane[7:0]};
      end
      2'b01: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = funct3[2] ? {16'b0, half_lane[15:0]}
                              : {{16{half_lane[15]}}, half_lane[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access on a req/ready + rvalid bus.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module load_store_unit
  import rv32i_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [31:0] InstCode,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [31:0] LoadData,
  output logic        MemReq,
  input  logic        MemReady,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBe,
  input  logic        MemRValid,
  input  logic [31:0] MemRData
);

  // state    | meaning
  // S_IDLE   | waiting for Start with a load/store opcode
  // S_REQ    | MemReq held with stable payload until MemReady
  // S_WAIT_R | load issued, waiting for MemRValid
  // S_DONE   | one-cycle Done (and Fault) pulse

  lsu_state_e  state;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        store_q;

  logic        is_ld, is_st, misalign, reject;
  logic [2:0]  f3_in;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        unused_inst;

  assign f3_in       = InstCode[14:12];
  assign is_ld       = (InstCode[6:0] == OPC_LOAD);
  assign is_st       = (InstCode[6:0] == OPC_STORE);
  assign unused_inst = ^{InstCode[31:15], InstCode[11:7]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = f3_misaligned(f3_in, Addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign reject = !f3_legal(is_st, f3_in) || misalign;

  // Request payload comes from the live inputs in IDLE; load extraction uses the latched access.
  assign al_f3 = (state == S_IDLE) ? f3_in : f3_q;
  assign al_lo = (state == S_IDLE) ? Addr[1:0] : lo_q;

  lsu_align u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .store_data (StoreData),
    .rdata      (MemRData),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      f3_q     <= 3'b0;
      lo_q     <= 2'b0;
      store_q  <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Fault    <= 1'b0;
      LoadData <= 32'b0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= 32'b0;
      MemWData <= 32'b0;
      MemBe    <= 4'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start && (is_ld || is_st)) begin
            f3_q    <= f3_in;
            lo_q    <= Addr[1:0];
            store_q <= is_st;
            Busy    <= 1'b1;
            if (reject) begin
              state <= S_DONE;
              Done  <= 1'b1;
              Fault <= 1'b1;
            end else begin
              state    <= S_REQ;
              MemReq   <= 1'b1;
              MemWe    <= is_st;
              MemAddr  <= {Addr[31:2], 2'b00};
              MemBe    <= al_be;
              MemWData <= al_wdata;
            end
          end
        end
        S_REQ: begin
          if (MemReady) begin
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
            if (store_q) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              state <= S_WAIT_R;
            end
          end
        end
        S_WAIT_R: begin
          if (MemRValid) begin
            LoadData <= al_load;
            state    <= S_DONE;
            Done     <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Fault <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses, expected bus requests
// and completions queued at issue and checked by an independent monitor.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] InstCode = 32'b0;
  logic [31:0] Addr = 32'b0;
  logic [31:0] StoreData = 32'b0;
  logic        Busy, Done, Fault, MemReq, MemWe;
  logic [31:0] LoadData, MemAddr, MemWData;
  logic [3:0]  MemBe;
  logic        MemReady = 1'b1;
  logic        MemRValid = 1'b0;
  logic [31:0] MemRData = 32'b0;

  load_store_unit dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .InstCode  (InstCode),
    .Addr      (Addr),
    .StoreData (StoreData),
    .Busy      (Busy),
    .Done      (Done),
    .Fault     (Fault),
    .LoadData  (LoadData),
    .MemReq    (MemReq),
    .MemReady  (MemReady),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemBe     (MemBe),
    .MemRValid (MemRValid),
    .MemRData  (MemRData)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  typedef struct packed {
    logic        fault;
    logic [31:0] ld;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  int req_cycles = 0;
  int done_cnt = 0;
  bit auto_resp = 1'b1;
  logic [31:0] resp_data = 32'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT hands off a request or completes.
  initial begin : monitor
    req_t  r;
    resp_t p;
    forever begin
      @(negedge Clk);
      if (Reset_n) begin
        if (MemReq) req_cycles++;
        if (MemReq && MemReady) begin
          hs_cnt++;
          if (req_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_req: got request at addr %h, expected none", MemAddr);
          end else begin
            r = req_q.pop_front();
            check("req_we", 64'(MemWe), 64'(r.we));
            check("req_addr", 64'(MemAddr), 64'(r.addr));
            check("req_be", 64'(MemBe), 64'(r.be));
            if (r.we) check("req_wdata", 64'(MemWData), 64'(r.wd));
          end
        end
        if (Done) begin
          done_cnt++;
          if (resp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got Done (fault %b), expected none", Fault);
          end else begin
            p = resp_q.pop_front();
            check("done_fault", 64'(Fault), 64'(p.fault));
            check("done_loaddata", 64'(LoadData), 64'(p.ld));
          end
        end
      end
    end
  end

  // Memory responder: read data one cycle after a load handshake.
  initial begin
    forever begin
      @(negedge Clk);
      if (auto_resp && Reset_n && MemReq && MemReady && !MemWe) begin
        @(posedge Clk);
        #1;
        MemRValid = 1'b1;
        MemRData  = resp_data;
        @(posedge Clk);
        #1;
        MemRValid = 1'b0;
        MemRData  = 32'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1);
  end

  task automatic run_access(
    input string       tag,
    input logic [31:0] inst,
    input logic [31:0] addr,
    input logic [31:0] sdata,
    input logic [31:0] rdata,
    input int          delay,
    input bit          poke,
    input int          exp_lat,
    input bit          exp_fault,
    input logic [31:0] exp_ld,
    input bit          exp_req,
    input bit          exp_we,
    input logic [31:0] exp_addr,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wd
  );
    int    lat;
    int    rc0;
    req_t  e;
    resp_t c;
    e.we = exp_we; e.addr = exp_addr; e.be = exp_be; e.wd = exp_wd;
    c.fault = exp_fault; c.ld = exp_ld;
    if (exp_req) req_q.push_back(e);
    resp_q.push_back(c);
    rc0 = req_cycles;
    resp_data = rdata;
    MemReady  = (delay == 0);
    InstCode  = inst;
    Addr      = addr;
    StoreData = sdata;
    Start     = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    lat   = 1;
    if (poke) begin
      Start     = 1'b1;
      InstCode  = 32'h0000_2023;
      Addr      = 32'h0000_0400;
      StoreData = 32'h5555_5555;
    end
    for (int i = 0; i < delay; i++) begin
      check({tag, "_hold_req"}, 64'({MemReq, MemAddr, MemBe}), 64'({1'b1, exp_addr, exp_be}));
      if (exp_we) check({tag, "_hold_wdata"}, 64'(MemWData), 64'(exp_wd));
      @(posedge Clk); #1;
      Start = 1'b0;
      lat++;
    end
    MemReady = 1'b1;
    while (!Done && lat < 20) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    @(posedge Clk); #1;
    check({tag, "_done_pulse_busy"}, 64'({Done, Busy}), 64'(0));
    check({tag, "_memreq_seen"}, 64'(req_cycles != rc0), 64'(exp_req));
  endtask

  initial begin
    int hs0, dc0, rc0;
    req_t e;

    #1 Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ctrl", 64'({Busy, Done, Fault, MemReq, MemWe}), 64'(0));
    check("rst_loaddata", 64'(LoadData), 64'(0));
    check("rst_bus", 64'({MemAddr, MemBe}), 64'(0));
    check("rst_wdata", 64'(MemWData), 64'(0));
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    //          tag    inst          addr          sdata         rdata        dly pk lat flt exp_ld        rq we addr          be     wd
    run_access("sw",   32'h0000_2023, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 2, 0, 32'h0000_0000, 1, 1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF);
    run_access("lb",   32'h0000_0003, 32'h0000_0203, 32'h0,         32'h80FF_FFFF, 0, 0, 3, 0, 32'hFFFF_FF80, 1, 0, 32'h0000_0200, 4'h8, 32'h0);
    run_access("lbu",  32'h0000_4003, 32'h0000_0203, 32'h0,         32'h80FF_FFFF, 0, 0, 3, 0, 32'h0000_0080, 1, 0, 32'h0000_0200, 4'h8, 32'h0);
    run_access("sh",   32'h0000_1023, 32'h0000_0002, 32'h1234_ABCD, 32'h0,        3, 0, 5, 0, 32'h0000_0080, 1, 1, 32'h0000_0000, 4'hC, 32'hABCD_ABCD);
    run_access("lh",   32'h0000_1003, 32'h0000_0206, 32'h0,         32'h8001_1234, 0, 0, 3, 0, 32'hFFFF_8001, 1, 0, 32'h0000_0204, 4'hC, 32'h0);
    run_access("lhu",  32'h0000_5003, 32'h0000_0204, 32'h0,         32'h8001_F234, 0, 0, 3, 0, 32'h0000_F234, 1, 0, 32'h0000_0204, 4'h3, 32'h0);
    run_access("sb",   32'h0000_0023, 32'h0000_0301, 32'h0000_00A5, 32'h0,        0, 0, 2, 0, 32'h0000_F234, 1, 1, 32'h0000_0300, 4'h2, 32'hA5A5_A5A5);
`ifdef LSU_MISALIGN_TRAP_EN
    run_access("lw_mis", 32'h0000_2003, 32'h0000_0101, 32'h0,       32'hCAFE_F00D, 0, 0, 1, 1, 32'h0000_F234, 0, 0, 32'h0,         4'h0, 32'h0);
    run_access("ld_ill", 32'h0000_3003, 32'h0000_0010, 32'h0,       32'h0,        0, 0, 1, 1, 32'h0000_F234, 0, 0, 32'h0,         4'h0, 32'h0);
    run_access("st_ill", 32'h0000_7023, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0,      0, 0, 1, 1, 32'h0000_F234, 0, 0, 32'h0,         4'h0, 32'h0);
`else
    run_access("lw_mis", 32'h0000_2003, 32'h0000_0101, 32'h0,       32'hCAFE_F00D, 0, 0, 3, 0, 32'hCAFE_F00D, 1, 0, 32'h0000_0100, 4'hF, 32'h0);
    run_access("ld_ill", 32'h0000_3003, 32'h0000_0010, 32'h0,       32'h0,        0, 0, 1, 1, 32'hCAFE_F00D, 0, 0, 32'h0,         4'h0, 32'h0);
    run_access("st_ill", 32'h0000_7023, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0,      0, 0, 1, 1, 32'hCAFE_F00D, 0, 0, 32'h0,         4'h0, 32'h0);
`endif

    // Start raised while busy (a store to 0x400) must not launch a second access.
    hs0 = hs_cnt;
    run_access("lhu_busy", 32'h0000_5003, 32'h0000_0102, 32'h0,   32'h7FFF_0000, 2, 1, 5, 0, 32'h0000_7FFF, 1, 0, 32'h0000_0100, 4'hC, 32'h0);
    repeat (3) @(posedge Clk);
    #1;
    check("busy_start_one_access", 64'(hs_cnt - hs0), 64'(1));
    check("busy_start_idle", 64'(Busy), 64'(0));

    // Non-memory opcode and a stray read response while idle are both ignored.
    dc0 = done_cnt;
    rc0 = req_cycles;
    InstCode  = 32'h0000_0033;
    Start     = 1'b1;
    MemRValid = 1'b1;
    MemRData  = 32'hFFFF_FFFF;
    @(posedge Clk); #1;
    Start     = 1'b0;
    MemRValid = 1'b0;
    check("nonmem_busy", 64'(Busy), 64'(0));
    repeat (2) @(posedge Clk);
    #1;
    check("nonmem_no_activity", 64'({done_cnt - dc0, req_cycles - rc0}), 64'(0));
    check("idle_rvalid_ignored", 64'(LoadData), 64'(32'h0000_7FFF));

    // Reset while waiting for read data abandons the access.
    auto_resp = 1'b0;
    e.we = 1'b0; e.addr = 32'h0000_0500; e.be = 4'hF; e.wd = 32'h0;
    req_q.push_back(e);
    MemReady = 1'b1;
    InstCode = 32'h0000_2003;
    Addr     = 32'h0000_0500;
    Start    = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    check("wait_r_busy", 64'({Busy, MemReq}), 64'(2'b10));
    dc0 = done_cnt;
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({Busy, Done, Fault, MemReq, MemWe}), 64'(0));
    check("async_rst_loaddata", 64'(LoadData), 64'(0));
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    MemRValid = 1'b1;
    MemRData  = 32'h1234_5678;
    @(posedge Clk); #1;
    MemRValid = 1'b0;
    MemRData  = 32'h0;
    repeat (3) @(posedge Clk);
    #1;
    check("late_rvalid_idle", 64'({Busy, Done}), 64'(0));
    check("late_rvalid_no_done", 64'(done_cnt - dc0), 64'(0));
    check("late_rvalid_loaddata", 64'(LoadData), 64'(0));
    auto_resp = 1'b1;

    run_access("lw_after_rst", 32'h0000_2003, 32'h0000_0000, 32'h0, 32'h1122_3344, 0, 0, 3, 0, 32'h1122_3344, 1, 0, 32'h0000_0000, 4'hF, 32'h0);

    repeat (2) @(posedge Clk);
    #1;
    check("scoreboard_drained", 64'(req_q.size() + resp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
